int_trigger: RTL and testbench

INT_TRIGGER -- requirements
Module: int_trigger

---
 rtl/int_trigger.sv | 133 +++++++++++++
 tb/tb_int_trigger.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/int_trigger.sv
// PC-triggered interrupt source: fires when the CPU PC reaches a programmable word address, acked/re-armed by stores.
// Build option INT_TRIGGER_PERIODIC_EN: after an ack, re-assert every PERIOD cycles instead of stopping in DONE.
module int_trigger #(
    parameter logic [31:0] TRIG_PC   = 32'h0000_3010,
    parameter logic [31:0] ACK_ADDR  = 32'h0000_7F20,
    parameter logic [31:0] CTRL_ADDR = 32'h0000_7F24,
    parameter logic [15:0] PERIOD    = 16'd8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] macroscopic_pc,
    input  logic [31:0] m_data_addr,
    input  logic [31:0] m_data_wdata,
    input  logic [3:0]  m_data_byteen,
    output logic        interrupt,
    output logic [7:0]  irq_count,
    output logic [1:0]  state
);

    localparam int unsigned CNT_W = 8;
    localparam logic [31:0] TRIG_PC_W   = {TRIG_PC[31:2], 2'b00};
    localparam logic [31:0] ACK_ADDR_W  = {ACK_ADDR[31:2], 2'b00};
    localparam logic [31:0] CTRL_ADDR_W = {CTRL_ADDR[31:2], 2'b00};

    typedef enum logic [1:0] {
        ST_ARMED  = 2'd0,
        ST_ASSERT = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        trig_pc_q, trig_pc_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               irq_q, irq_d;

    logic               store;
    logic               ctrl_hit;
    logic               ack_hit;
    logic               pc_hit;

    assign store    = |m_data_byteen;
    assign ctrl_hit = store && ({m_data_addr[31:2], 2'b00} == CTRL_ADDR_W);
    assign ack_hit  = store && ({m_data_addr[31:2], 2'b00} == ACK_ADDR_W);
    assign pc_hit   = ({macroscopic_pc[31:2], 2'b00} == trig_pc_q);

`ifdef INT_TRIGGER_PERIODIC_EN
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic [3:0]  unused_bits;
    assign unused_bits = {macroscopic_pc[1:0], m_data_addr[1:0]} ^ {2'b00, m_data_wdata[1:0]};
`else
    logic [19:0] unused_bits;
    assign unused_bits = {PERIOD, macroscopic_pc[1:0], m_data_addr[1:0]} ^ {18'd0, m_data_wdata[1:0]};
`endif

    // State, trigger PC, assertion counter and interrupt register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_ARMED;
            trig_pc_q  <= TRIG_PC_W;
            count_q    <= '0;
            irq_q      <= 1'b0;
`ifdef INT_TRIGGER_PERIODIC_EN
            wait_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            trig_pc_q  <= trig_pc_d;
            count_q    <= count_d;
            irq_q      <= irq_d;
`ifdef INT_TRIGGER_PERIODIC_EN
            wait_cnt_q <= wait_cnt_d;
`endif
        end
    end

    // Next state: CTRL store beats ACK store beats PC match
    always_comb begin
        state_d   = state_q;
        trig_pc_d = trig_pc_q;
        count_d   = count_q;
`ifdef INT_TRIGGER_PERIODIC_EN
        wait_cnt_d = wait_cnt_q;
`endif
        if (ctrl_hit) begin
            trig_pc_d = {m_data_wdata[31:2], 2'b00};
            state_d   = ST_ARMED;
`ifdef INT_TRIGGER_PERIODIC_EN
            wait_cnt_d = '0;
`endif
        end else begin
            case (state_q)
                ST_ARMED: begin
                    if (pc_hit) state_d = ST_ASSERT;
                end
                ST_ASSERT: begin
                    if (ack_hit) begin
`ifdef INT_TRIGGER_PERIODIC_EN
                        state_d    = ST_WAIT;
                        wait_cnt_d = PERIOD - 16'd1;
`else
                        state_d    = ST_DONE;
`endif
                    end
                end
                ST_WAIT: begin
`ifdef INT_TRIGGER_PERIODIC_EN
                    if (wait_cnt_q == 16'd0) state_d = ST_ASSERT;
                    else                     wait_cnt_d = wait_cnt_q - 16'd1;
`else
                    state_d = ST_DONE;
`endif
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_ARMED;
                end
            endcase
        end
        // Count each entry into ASSERT, saturating
        if ((state_d == ST_ASSERT) && (state_q != ST_ASSERT) && (count_q != 8'hFF)) begin
            count_d = count_q + CNT_W'(1);
        end
        irq_d = (state_d == ST_ASSERT);
    end

    assign interrupt = irq_q;
    assign irq_count = count_q;
    assign state     = state_q;

endmodule

// File: tb/tb_int_trigger.sv
// Scoreboard bench for int_trigger: each driven cycle queues its expected state/interrupt/count, a monitor compares after the edge.
module tb_int_trigger;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] macroscopic_pc = 32'h0;
    logic [31:0] m_data_addr = 32'h0;
    logic [31:0] m_data_wdata = 32'h0;
    logic [3:0]  m_data_byteen = 4'h0;
    logic        interrupt;
    logic [7:0]  irq_count;
    logic [1:0]  state;

    int errors = 0;
    int checks = 0;

    localparam logic [1:0] S_ARMED  = 2'd0;
    localparam logic [1:0] S_ASSERT = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    typedef struct {
        logic [1:0] st;
        logic       irq;
        logic [7:0] cnt;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;

    int_trigger dut (
        .clk            (clk),
        .reset          (reset),
        .macroscopic_pc (macroscopic_pc),
        .m_data_addr    (m_data_addr),
        .m_data_wdata   (m_data_wdata),
        .m_data_byteen  (m_data_byteen),
        .interrupt      (interrupt),
        .irq_count      (irq_count),
        .state          (state)
    );

    always #5 clk = ~clk;

    // Scoreboard: compare the expectation queued for this edge
    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (state !== e.st) begin
                errors++;
                $display("FAIL %s state: got %0d want %0d", e.name, state, e.st);
            end
            checks++;
            if (interrupt !== e.irq) begin
                errors++;
                $display("FAIL %s interrupt: got %b want %b", e.name, interrupt, e.irq);
            end
            checks++;
            if (irq_count !== e.cnt) begin
                errors++;
                $display("FAIL %s irq_count: got %0d want %0d", e.name, irq_count, e.cnt);
            end
        end
    end

    task automatic drive(input logic rst, input logic [31:0] pc, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be,
                         input logic [1:0] st, input logic irq, input logic [7:0] cnt,
                         input string nm);
        exp_t x;
        @(negedge clk);
        reset          = rst;
        macroscopic_pc = pc;
        m_data_addr    = addr;
        m_data_wdata   = wdata;
        m_data_byteen  = be;
        x.st = st; x.irq = irq; x.cnt = cnt; x.name = nm;
        exp_q.push_back(x);
        @(posedge clk);
    endtask

    task automatic test_reset();
        // Reset with a PC match and a CTRL store pending: both ignored
        drive(1'b1, 32'h3010, 32'h7F24, 32'h5000, 4'hF, S_ARMED, 1'b0, 8'd0, "reset_with_inputs");
        drive(1'b1, 32'h3000, 32'h0, 32'h0, 4'h0, S_ARMED, 1'b0, 8'd0, "reset_hold");
        #2;
        checks++;
        if (irq_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_count_inline: got %0d want 0", irq_count);
        end
    endtask

    task automatic test_trigger();
        drive(1'b0, 32'h3000, 32'h0, 32'h0, 4'h0, S_ARMED, 1'b0, 8'd0, "pc_3000");
        drive(1'b0, 32'h3004, 32'h0, 32'h0, 4'h0, S_ARMED, 1'b0, 8'd0, "pc_3004");
        drive(1'b0, 32'h3008, 32'h0, 32'h0, 4'h0, S_ARMED, 1'b0, 8'd0, "pc_3008");
        drive(1'b0, 32'h300C, 32'h0, 32'h0, 4'h0, S_ARMED, 1'b0, 8'd0, "pc_300c");
        drive(1'b0, 32'h3010, 32'h0, 32'h0, 4'h0, S_ASSERT, 1'b1, 8'd1, "pc_3010_fire");
        drive(1'b0, 32'h3014, 32'h0, 32'h0, 4'h0, S_ASSERT, 1'b1, 8'd1, "pc_3014_hold");
        drive(1'b0, 32'h3010, 32'h0, 32'h0, 4'h0, S_ASSERT, 1'b1, 8'd1, "pc_3010_again");
    endtask

    task automatic test_ack_oneshot();
        drive(1'b0, 32'h3018, 32'h7F22, 32'h0, 4'b0011, S_DONE, 1'b0, 8'd1, "ack_byte_addr");
        drive(1'b0, 32'h3010, 32'h0, 32'h0, 4'h0, S_DONE, 1'b0, 8'd1, "done_pc_match");
        drive(1'b0, 32'h3010, 32'h7F20, 32'h0, 4'hF, S_DONE, 1'b0, 8'd1, "done_ack_ignored");
        drive(1'b0, 32'h3000, 32'h7F24, 32'h3000, 4'h0, S_DONE, 1'b0, 8'd1, "ctrl_no_byteen");
    endtask

    task automatic test_ctrl_rearm();
        // PC already equals the new trigger on the CTRL edge: must not fire yet
        drive(1'b0, 32'h3044, 32'h7F24, 32'h3047, 4'hF, S_ARMED, 1'b0, 8'd1, "ctrl_rearm_3044");
        drive(1'b0, 32'h3044, 32'h0, 32'h0, 4'h0, S_ASSERT, 1'b1, 8'd2, "pc_3044_fire");
        drive(1'b0, 32'h3048, 32'h0, 32'h0, 4'h0, S_ASSERT, 1'b1, 8'd2, "pc_3048_hold");
    endtask

    task automatic test_ack_armed();
        drive(1'b0, 32'h3000, 32'h7F20, 32'h0, 4'h1, S_DONE, 1'b0, 8'd2, "ack_to_done");
        drive(1'b0, 32'h3000, 32'h7F24, 32'h3010, 4'hF, S_ARMED, 1'b0, 8'd2, "ctrl_3010");
        drive(1'b0, 32'h3000, 32'h7F20, 32'h0, 4'hF, S_ARMED, 1'b0, 8'd2, "armed_ack_ignored");
        drive(1'b0, 32'h3013, 32'h0, 32'h0, 4'h0, S_ASSERT, 1'b1, 8'd3, "pc_low_bits_fire");
    endtask

    task automatic test_other_store();
        drive(1'b0, 32'h3000, 32'h7F28, 32'h1, 4'hF, S_ASSERT, 1'b1, 8'd3, "store_7f28");
        drive(1'b0, 32'h3000, 32'h7F1C, 32'h1, 4'hF, S_ASSERT, 1'b1, 8'd3, "store_7f1c");
        drive(1'b0, 32'h3000, 32'h7F20, 32'h1, 4'h0, S_ASSERT, 1'b1, 8'd3, "ack_no_byteen");
    endtask

    task automatic test_saturation();
        logic [7:0] c = 8'd3;
        for (int i = 0; i < 256; i++) begin
            drive(1'b0, 32'h3010, 32'h7F24, 32'h3010, 4'hF, S_ARMED, 1'b0, c, "sat_rearm");
            c = (c == 8'hFF) ? 8'hFF : c + 8'd1;
            drive(1'b0, 32'h3010, 32'h0, 32'h0, 4'h0, S_ASSERT, 1'b1, c, "sat_fire");
        end
        #2;
        checks++;
        if (irq_count !== 8'hFF) begin
            errors++;
            $display("FAIL saturate_inline: got %0d want 255", irq_count);
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 32'h3010, 32'h7F24, 32'h5000, 4'hF, S_ARMED, 1'b0, 8'd0, "reset_mid_assert");
        drive(1'b0, 32'h3010, 32'h0, 32'h0, 4'h0, S_ASSERT, 1'b1, 8'd1, "after_reset_fire");
    endtask

`ifdef INT_TRIGGER_PERIODIC_EN
    task automatic test_periodic();
        logic [7:0] c = 8'd1;
        for (int a = 0; a < 3; a++) begin
            drive(1'b0, 32'h3000, 32'h7F20, 32'h0, 4'hF, S_WAIT, 1'b0, c, "per_ack");
            for (int k = 1; k < 8; k++) begin
                if (k == 3)
                    drive(1'b0, 32'h3010, 32'h7F20, 32'h0, 4'hF, S_WAIT, 1'b0, c, "per_wait_ignored");
                else
                    drive(1'b0, 32'h3000, 32'h0, 32'h0, 4'h0, S_WAIT, 1'b0, c, "per_wait");
            end
            c = c + 8'd1;
            drive(1'b0, 32'h3000, 32'h0, 32'h0, 4'h0, S_ASSERT, 1'b1, c, "per_reassert");
        end
    endtask

    task automatic test_reset_wait();
        drive(1'b0, 32'h3000, 32'h7F20, 32'h0, 4'hF, S_WAIT, 1'b0, 8'd4, "rw_ack");
        for (int k = 0; k < 4; k++)
            drive(1'b0, 32'h3000, 32'h0, 32'h0, 4'h0, S_WAIT, 1'b0, 8'd4, "rw_wait");
        drive(1'b1, 32'h3000, 32'h0, 32'h0, 4'h0, S_ARMED, 1'b0, 8'd0, "rw_reset");
        for (int k = 0; k < 5; k++)
            drive(1'b0, 32'h3000, 32'h0, 32'h0, 4'h0, S_ARMED, 1'b0, 8'd0, "rw_no_reassert");
    endtask
`endif

    initial begin
        test_reset();
        test_trigger();
`ifdef INT_TRIGGER_PERIODIC_EN
        test_periodic();
        test_reset_wait();
`else
        test_ack_oneshot();
        test_ctrl_rearm();
        test_ack_armed();
        test_other_store();
        test_saturation();
        test_reset_mid();
`endif
        @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
